// File: rtl/scaler_hist_buf_pkg.sv
// rtl/scaler_hist_buf_pkg.sv - shared scaler constants: discr_scaler widths and history entry layout
// Contents: discr_scaler count width, history entry field widths/offsets
// (count at LSBs, then valid, then seq), overflow counter width.
package scaler_hist_buf_pkg;

  // discr_scaler side
  localparam int DS_N_WIDTH = 16;  // width of discr_scaler n_pedge_out

  // history entry layout: {seq, valid, count}
  localparam int HB_SEQ_W     = 8;
  localparam int HB_VALID_W   = 1;
  localparam int HB_COUNT_LSB = 0;
  localparam int HB_OVF_W     = 16;

  function automatic int hb_valid_lsb(input int n_width);
    return HB_COUNT_LSB + n_width;
  endfunction

  function automatic int hb_seq_lsb(input int n_width);
    return hb_valid_lsb(n_width) + HB_VALID_W;
  endfunction

  function automatic int hb_entry_w(input int n_width);
    return hb_seq_lsb(n_width) + HB_SEQ_W;
  endfunction

endpackage

// File: rtl/sdp_ram.sv
// rtl/sdp_ram.sv - simple dual-port RAM, registered read with 1-cycle latency
// Ports: clk; rst clears only the read register (array is not reset);
// we/waddr/wdata write port; re/raddr read port; rdata holds its value
// until the next re. A same-address read and write returns the old word.
module sdp_ram #(
  parameter int P_WIDTH     = 25,
  parameter int P_ADDR_BITS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [P_ADDR_BITS-1:0] waddr,
  input  logic [P_WIDTH-1:0]     wdata,
  input  logic                   re,
  input  logic [P_ADDR_BITS-1:0] raddr,
  output logic [P_WIDTH-1:0]     rdata
);

  logic [P_WIDTH-1:0] mem [1<<P_ADDR_BITS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/scaler_hist_buf.sv
// rtl/scaler_hist_buf.sv - history FIFO of discr_scaler update results
// Ports: clk, rst (sync, active high); update_in/valid_in/n_pedge_in update
// strobe and payload; flush empties the buffer; rd_req -> rd_ack one cycle
// later with rd_data {seq, valid, count} and rd_err (empty or flushed);
// fill entry count; latest last valid count; overflow_cnt saturating drops.
module scaler_hist_buf
  import scaler_hist_buf_pkg::*;
#(
  parameter int P_N_WIDTH    = DS_N_WIDTH,
  parameter int P_DEPTH_LOG2 = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      update_in,
  input  logic                      valid_in,
  input  logic [P_N_WIDTH-1:0]      n_pedge_in,
  input  logic                      flush,
  input  logic                      rd_req,
  output logic                      rd_ack,
  output logic [P_N_WIDTH+8:0]      rd_data,
  output logic                      rd_err,
  output logic [P_DEPTH_LOG2:0]     fill,
  output logic [P_N_WIDTH-1:0]      latest,
  output logic [HB_OVF_W-1:0]       overflow_cnt
);

  localparam int EW    = hb_entry_w(P_N_WIDTH);
  localparam int DEPTH = 1 << P_DEPTH_LOG2;
  localparam logic [P_DEPTH_LOG2:0] FILL_FULL = (P_DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [HB_OVF_W-1:0]   OVF_ONE   = 1;
  localparam logic [HB_OVF_W-1:0]   OVF_MAX   = '1;

  logic [P_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [P_DEPTH_LOG2:0]   fill_q;
  logic [HB_SEQ_W-1:0]     seq;
  logic [P_N_WIDTH-1:0]    latest_q;
  logic [HB_OVF_W-1:0]     ovf_q;
  logic                    ack_q, err_q;
  logic                    data_zero;  // last response was an error (or reset): present zeros
  logic [EW-1:0]           ram_q;
  logic [EW-1:0]           wr_entry;

  logic rd_take, wr_take, drop;

  // A read frees a slot in the same cycle, so a full buffer still accepts
  // a write alongside a read. An empty buffer never bypasses a write to a
  // same-cycle read. Flush overrides both.
  always_comb begin
    rd_take  = rd_req && !flush && (fill_q != '0);
    wr_take  = update_in && !flush && ((fill_q != FILL_FULL) || rd_take);
    drop     = update_in && !flush && (fill_q == FILL_FULL) && !rd_take;
    wr_entry = {seq, valid_in, n_pedge_in};
  end

  sdp_ram #(
    .P_WIDTH    (EW),
    .P_ADDR_BITS(P_DEPTH_LOG2)
  ) u_ram (
    .clk  (clk),
    .rst  (rst),
    .we   (wr_take && !rst),
    .waddr(wr_ptr),
    .wdata(wr_entry),
    .re   (rd_take && !rst),
    .raddr(rd_ptr),
    .rdata(ram_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fill_q    <= '0;
      seq       <= '0;
      latest_q  <= '0;
      ovf_q     <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      data_zero <= 1'b1;
    end else begin
      ack_q <= rd_req;
      if (rd_req) begin
        err_q     <= !rd_take;
        data_zero <= !rd_take;
      end

      if (update_in) begin
        seq <= seq + 8'd1;
        if (valid_in) latest_q <= n_pedge_in;
      end

      if (drop && (ovf_q != OVF_MAX)) ovf_q <= ovf_q + OVF_ONE;

      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        fill_q <= '0;
      end else begin
        if (wr_take) wr_ptr <= wr_ptr + 1'b1;
        if (rd_take) rd_ptr <= rd_ptr + 1'b1;
        fill_q <= fill_q + (P_DEPTH_LOG2 + 1)'(wr_take) - (P_DEPTH_LOG2 + 1)'(rd_take);
      end
    end
  end

  assign rd_ack       = ack_q;
  assign rd_err       = err_q;
  assign rd_data      = data_zero ? '0 : ram_q;
  assign fill         = fill_q;
  assign latest       = latest_q;
  assign overflow_cnt = ovf_q;

endmodule

// File: tb/tb_scaler_hist_buf.sv
// tb/tb_scaler_hist_buf.sv - self-checking bench for scaler_hist_buf
// Drives a directed vector table, hand sequences for the corner cases and
// random traffic; every cycle is compared against a queue-based model.
module tb_scaler_hist_buf;

  logic        clk = 1'b0;
  logic        rst, update_in, valid_in, flush, rd_req;
  logic [15:0] n_pedge_in;
  logic        rd_ack, rd_err;
  logic [24:0] rd_data;
  logic [4:0]  fill;
  logic [15:0] latest, overflow_cnt;

  always #5 clk = ~clk;

  scaler_hist_buf dut (
    .clk(clk), .rst(rst), .update_in(update_in), .valid_in(valid_in),
    .n_pedge_in(n_pedge_in), .flush(flush), .rd_req(rd_req),
    .rd_ack(rd_ack), .rd_data(rd_data), .rd_err(rd_err), .fill(fill),
    .latest(latest), .overflow_cnt(overflow_cnt)
  );

  int errors = 0;
  int checks = 0;

  // reference model
  logic [24:0] mq[$];
  logic [7:0]  m_seq;
  logic [15:0] m_latest, m_ovf;
  logic        m_ack, m_err;
  logic [24:0] m_data;

  typedef struct {
    logic        upd, vld;
    logic [15:0] n;
    logic        fl, rd;
    logic        e_ack, e_err;
    logic [24:0] e_data;
    logic [4:0]  e_fill;
    logic [15:0] e_latest;
  } vec_t;
  vec_t tbl[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic u, input logic v, input logic [15:0] n,
                      input logic f, input logic rq, input bit chk);
    rst = r; update_in = u; valid_in = v; n_pedge_in = n; flush = f; rd_req = rq;
    @(posedge clk);
    if (r) begin
      mq.delete();
      m_seq = 0; m_latest = 0; m_ovf = 0; m_ack = 0; m_err = 0; m_data = 0;
    end else begin
      m_ack = rq;
      if (rq) begin
        if (!f && mq.size() > 0) begin
          m_data = mq.pop_front();
          m_err  = 0;
        end else begin
          m_data = 0;
          m_err  = 1;
        end
      end
      if (u) begin
        if (!f) begin
          if (mq.size() < 16) mq.push_back({m_seq, v, n});
          else if (m_ovf != 16'hffff) m_ovf++;
        end
        m_seq++;
        if (v) m_latest = n;
      end
      if (f) mq.delete();
    end
    #1;
    if (chk) begin
      check("rd_ack", 32'(rd_ack), 32'(m_ack));
      if (m_ack) check("rd_err", 32'(rd_err), 32'(m_err));
      check("rd_data", 32'(rd_data), 32'(m_data));
      check("fill", 32'(fill), 32'(mq.size()));
      check("latest", 32'(latest), 32'(m_latest));
      check("overflow_cnt", 32'(overflow_cnt), 32'(m_ovf));
    end
  endtask

  task automatic idle(input bit chk);
    step(0, 0, 0, 16'd0, 0, 0, chk);
  endtask

  task automatic do_reset();
    step(1, 0, 0, 16'd0, 0, 0, 1);
    step(1, 0, 0, 16'd0, 0, 0, 1);
  endtask

  initial begin
    logic [15:0] saved_n;
    logic        saved_v;

    tbl[0] = '{1, 1, 16'd5, 0, 0, 0, 0, 25'd0, 5'd1, 16'd5};
    tbl[1] = '{1, 0, 16'd0, 0, 0, 0, 0, 25'd0, 5'd2, 16'd5};
    tbl[2] = '{1, 1, 16'd7, 0, 0, 0, 0, 25'd0, 5'd3, 16'd7};
    tbl[3] = '{0, 0, 16'd0, 0, 1, 1, 0, {8'd0, 1'b1, 16'd5}, 5'd2, 16'd7};
    tbl[4] = '{0, 0, 16'd0, 0, 1, 1, 0, {8'd1, 1'b0, 16'd0}, 5'd1, 16'd7};
    tbl[5] = '{0, 0, 16'd0, 0, 1, 1, 0, {8'd2, 1'b1, 16'd7}, 5'd0, 16'd7};
    tbl[6] = '{0, 0, 16'd0, 0, 1, 1, 1, 25'd0, 5'd0, 16'd7};

    // reset state
    do_reset();
    check("reset_ack", 32'(rd_ack), 32'd0);
    check("reset_fill", 32'(fill), 32'd0);
    check("reset_data", 32'(rd_data), 32'd0);

    // three updates then three reads plus one on empty
    for (int i = 0; i < 7; i++) begin
      step(0, tbl[i].upd, tbl[i].vld, tbl[i].n, tbl[i].fl, tbl[i].rd, 1);
      check($sformatf("tbl%0d_ack", i), 32'(rd_ack), 32'(tbl[i].e_ack));
      if (tbl[i].e_ack) begin
        check($sformatf("tbl%0d_err", i), 32'(rd_err), 32'(tbl[i].e_err));
        check($sformatf("tbl%0d_data", i), 32'(rd_data), 32'(tbl[i].e_data));
      end
      check($sformatf("tbl%0d_fill", i), 32'(fill), 32'(tbl[i].e_fill));
      check($sformatf("tbl%0d_latest", i), 32'(latest), 32'(tbl[i].e_latest));
    end

    // 18 updates into an empty buffer, then drain with 17 reads
    do_reset();
    for (int i = 0; i < 18; i++) step(0, 1, 1'($urandom), 16'($urandom), 0, 0, 1);
    check("ovf18_fill", 32'(fill), 32'd16);
    check("ovf18_cnt", 32'(overflow_cnt), 32'd2);
    for (int i = 0; i < 17; i++) begin
      step(0, 0, 0, 16'd0, 0, 1, 1);
      if (i == 0)  check("ovf18_first_seq", 32'(rd_data[24:17]), 32'd0);
      if (i == 15) check("ovf18_16th_seq", 32'(rd_data[24:17]), 32'd15);
      if (i == 16) check("ovf18_17th_err", 32'(rd_err), 32'd1);
    end

    // full buffer: write and read in the same cycle
    do_reset();
    for (int i = 0; i < 16; i++) step(0, 1, 1, 16'(i + 100), 0, 0, 1);
    step(0, 1, 1, 16'd999, 0, 1, 1);
    check("full_rw_seq", 32'(rd_data[24:17]), 32'd0);
    check("full_rw_fill", 32'(fill), 32'd16);
    check("full_rw_ovf", 32'(overflow_cnt), 32'd0);
    for (int i = 0; i < 16; i++) step(0, 0, 0, 16'd0, 0, 1, 1);

    // empty buffer: write and read in the same cycle
    do_reset();
    saved_n = 16'($urandom);
    saved_v = 1'($urandom);
    step(0, 1, saved_v, saved_n, 0, 1, 1);
    check("empty_rw_ack", 32'(rd_ack), 32'd1);
    check("empty_rw_err", 32'(rd_err), 32'd1);
    check("empty_rw_fill", 32'(fill), 32'd1);
    step(0, 0, 0, 16'd0, 0, 1, 1);
    check("empty_rw_next", 32'(rd_data), 32'({8'd0, saved_v, saved_n}));
    check("empty_rw_next_err", 32'(rd_err), 32'd0);

    // flush with a same-cycle read
    do_reset();
    for (int i = 0; i < 4; i++) step(0, 1, 1, 16'(i), 0, 0, 1);
    step(0, 0, 0, 16'd0, 1, 1, 1);
    check("flush_err", 32'(rd_err), 32'd1);
    check("flush_fill", 32'(fill), 32'd0);
    step(0, 1, 1, 16'd42, 0, 0, 1);
    step(0, 0, 0, 16'd0, 0, 1, 1);
    check("flush_next_seq", 32'(rd_data[24:17]), 32'd4);
    check("flush_kept_latest", 32'(latest), 32'd42);

    // reset while a read is requested suppresses the response
    step(0, 1, 1, 16'd3, 0, 0, 1);
    step(1, 0, 0, 16'd0, 0, 1, 1);
    check("rst_read_ack", 32'(rd_ack), 32'd0);
    check("rst_read_fill", 32'(fill), 32'd0);
    idle(1);

    // 300 updates with random interleaved reads and flushes
    do_reset();
    for (int i = 0; i < 300; i++)
      step(0, 1, 1'($urandom), 16'($urandom), ($urandom_range(0, 49) == 0),
           ($urandom_range(0, 3) == 0), 1);
    for (int i = 0; i < 40; i++)
      step(0, 1'($urandom), 1'($urandom), 16'($urandom), 0, 1'($urandom), 1);

    // overflow counter saturation under sustained drops
    do_reset();
    for (int i = 0; i < 65560; i++) step(0, 1, 1, 16'(i), 0, 0, 0);
    step(0, 1, 1, 16'd1, 0, 0, 1);
    check("ovf_saturated", 32'(overflow_cnt), 32'hffff);
    step(0, 0, 0, 16'd0, 0, 1, 1);
    idle(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
